// File: rtl/irq_trigger_cond.sv
// irq_trigger_cond: per-line synchronise, polarity, debounce, mask and edge/level trigger with sticky pending/overrun
module irq_trigger_cond #(
  parameter int N_IRQ   = 4,
  parameter int DEB_W   = 4,
  parameter int DEB_CNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_pol,
  input  logic [N_IRQ-1:0] irq_edge,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic [N_IRQ-1:0] pend_clr,
  output logic [N_IRQ-1:0] irq_trigger,
  output logic [N_IRQ-1:0] irq_pending,
  output logic [N_IRQ-1:0] irq_overrun
);
  logic [N_IRQ-1:0] s1_q, s2_q, flt_q, flt_d, trig_q, trig_d, pend_q, pend_d, ovr_q, ovr_d, act, q;
  logic [DEB_W-1:0] cnt_q [N_IRQ];
  logic [DEB_W-1:0] cnt_d [N_IRQ];
  always_comb begin
    flt_d = flt_q;
    cnt_d = cnt_q;
    act = ~(s2_q ^ irq_pol);
    for (int i = 0; i < N_IRQ; i++) begin
      flt_d[i] = (act[i] != flt_q[i] && cnt_q[i] == DEB_W'(DEB_CNT - 1)) ? act[i] : flt_q[i];
      cnt_d[i] = (act[i] == flt_q[i] || cnt_q[i] == DEB_W'(DEB_CNT - 1)) ? '0 : cnt_q[i] + DEB_W'(1);
    end
    q = {N_IRQ{enable}} & ~irq_mask & ((irq_edge & flt_d & ~flt_q) | (~irq_edge & flt_d));
    trig_d = q;
    pend_d = q | (pend_q & ~pend_clr);
    ovr_d = (q & irq_edge & pend_q & ~pend_clr) | (ovr_q & ~pend_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      flt_q  <= '0;
      cnt_q  <= '{default: '0};
      trig_q <= '0;
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      s1_q   <= irq_in;
      s2_q   <= s1_q;
      flt_q  <= flt_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end
  assign irq_trigger = trig_q;
  assign irq_pending = pend_q;
  assign irq_overrun = ovr_q;
endmodule

// File: tb/tb_irq_trigger_cond.sv
// tb_irq_trigger_cond: directed and random stimulus checked against a sliding-window reference model
module tb_irq_trigger_cond;
  localparam int N = 4;
  localparam int DW = 4;
  localparam int DC = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic [N-1:0] irq_in = '0, irq_pol = '1, irq_edge = '1, irq_mask = '0, pend_clr = '0;
  logic [N-1:0] irq_trigger, irq_pending, irq_overrun;
  logic [N-1:0] m_s1, m_s2, m_flt, m_trig, m_pend, m_ovr;
  logic [N-1:0] m_hist [DC];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_trigger_cond #(.N_IRQ(N), .DEB_W(DW), .DEB_CNT(DC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .irq_in(irq_in), .irq_pol(irq_pol),
    .irq_edge(irq_edge), .irq_mask(irq_mask), .pend_clr(pend_clr),
    .irq_trigger(irq_trigger), .irq_pending(irq_pending), .irq_overrun(irq_overrun)
  );

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    {m_s1, m_s2, m_flt, m_trig, m_pend, m_ovr} = '0;
    for (int k = 0; k < DC; k++) m_hist[k] = '0;
  endtask

  // filtered level flips once the last DC synchronised samples all disagree with it
  task automatic model_step();
    logic [N-1:0] act, fn, q;
    bit flip;
    act = ~(m_s2 ^ irq_pol);
    for (int k = DC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = act;
    fn = m_flt;
    for (int i = 0; i < N; i++) begin
      flip = 1'b1;
      for (int k = 0; k < DC; k++) if (m_hist[k][i] == m_flt[i]) flip = 1'b0;
      if (flip) fn[i] = ~m_flt[i];
    end
    q = '0;
    for (int i = 0; i < N; i++)
      q[i] = enable && !irq_mask[i] && (irq_edge[i] ? (fn[i] && !m_flt[i]) : fn[i]);
    m_ovr  = (q & irq_edge & m_pend & ~pend_clr) | (m_ovr & ~pend_clr);
    m_pend = q | (m_pend & ~pend_clr);
    m_trig = q;
    m_flt  = fn;
    m_s2   = m_s1;
    m_s1   = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("trigger", irq_trigger, m_trig);
    check("pending", irq_pending, m_pend);
    check("overrun", irq_overrun, m_ovr);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_trigger", irq_trigger, '0);
    check("reset_pending", irq_pending, '0);
    check("reset_overrun", irq_overrun, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(4);
    irq_in[0] = 1'b1; ticks(10);
    irq_in[0] = 1'b0; ticks(8);
    irq_in[1] = 1'b1; ticks(2);
    irq_in[1] = 1'b0; ticks(6);
    irq_in[1] = 1'b1; ticks(3);
    irq_in[1] = 1'b0; ticks(6);
    irq_in[2] = 1'b1; irq_pol[2] = 1'b0; irq_edge[2] = 1'b0; ticks(6);
    irq_in[2] = 1'b0; ticks(8);
    irq_in[2] = 1'b1; ticks(8);
    irq_mask[3] = 1'b1; irq_in[3] = 1'b1; ticks(6);
    irq_mask[3] = 1'b0; ticks(6);
    irq_in[3] = 1'b0; ticks(6);
    enable = 1'b0; irq_in[0] = 1'b1; ticks(6);
    enable = 1'b1; ticks(6);
    irq_in[0] = 1'b0; ticks(6);
    pend_clr = '1; tick(); pend_clr = '0;
    irq_in[0] = 1'b1; ticks(6); irq_in[0] = 1'b0; ticks(6);
    irq_in[0] = 1'b1; ticks(6); irq_in[0] = 1'b0; ticks(6);
    pend_clr[0] = 1'b1; tick(); pend_clr[0] = 1'b0; ticks(2);
    irq_in[0] = 1'b1; ticks(6); irq_in[0] = 1'b0; ticks(6);
    irq_in[0] = 1'b1; ticks(4);
    pend_clr[0] = 1'b1; tick(); pend_clr[0] = 1'b0; ticks(4);
    irq_in[0] = 1'b0; ticks(6);
    irq_in[1] = 1'b1; ticks(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_trigger", irq_trigger, '0);
    check("async_rst_pending", irq_pending, '0);
    check("async_rst_overrun", irq_overrun, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ticks(10);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) irq_in[i] = ~irq_in[i];
        if ($urandom_range(0, 60) == 0) irq_pol[i] = ~irq_pol[i];
        if ($urandom_range(0, 60) == 0) irq_edge[i] = ~irq_edge[i];
        if ($urandom_range(0, 50) == 0) irq_mask[i] = ~irq_mask[i];
        pend_clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 40) == 0) enable = ~enable;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
